// File: rtl/npu_cmd_decoder.sv
// npu_cmd_decoder
//   Registered NPU bus decoder. Each enabled access is classified by region.
//   The result appears one cycle later as an access strobe carrying a
//   region-relative offset. Op-launch writes are queued in a command FIFO that
//   the NPU sequencer drains through a valid/ready handshake. Unmapped or
//   illegal accesses and FIFO overflow raise sticky error flags.
//
// Optional build macro: NPU_DEC_PERF_CNT_EN
//   When defined, the block adds the saturating counters cmd_cnt_o and
//   drop_cnt_o.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   cen_i, wen_i          bus access enable; 1 = write, 0 = read
//   addr_i, wdata_i       byte address and write data
//   acc_valid_o           one-cycle strobe for a decoded memory/param access
//   op_type_o             registered op/region code
//   acc_we_o              registered write flag of the last decoded access
//   acc_offs_o            registered region-relative offset
//   acc_wdata_o           registered write data
//   cmd_valid_o           command FIFO holds at least one entry
//   cmd_ready_i           sequencer accepts the head command
//   cmd_op_o, cmd_arg_o   head command: op index k and its argument
//   busy_o                command FIFO holds at least one entry
//   dec_err_o, ovf_err_o  sticky decode error and sticky FIFO overflow
//   err_clr_i             clears both sticky errors (and the perf counters)
//   cmd_cnt_o, drop_cnt_o accepted and dropped pushes (NPU_DEC_PERF_CNT_EN only)
module npu_cmd_decoder #(
  parameter int unsigned DWidth     = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_OPS    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cen_i,
  input  logic                       wen_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [DWidth-1:0]          wdata_i,
  output logic                       acc_valid_o,
  output logic [3:0]                 op_type_o,
  output logic                       acc_we_o,
  output logic [ADDR_WIDTH-1:0]      acc_offs_o,
  output logic [DWidth-1:0]          acc_wdata_o,
  output logic                       cmd_valid_o,
  input  logic                       cmd_ready_i,
  output logic [$clog2(NUM_OPS)-1:0] cmd_op_o,
  output logic [DWidth-1:0]          cmd_arg_o,
  output logic                       busy_o,
  output logic                       dec_err_o,
  output logic                       ovf_err_o,
`ifdef NPU_DEC_PERF_CNT_EN
  output logic [15:0]                cmd_cnt_o,
  output logic [15:0]                drop_cnt_o,
`endif
  input  logic                       err_clr_i
);

  localparam int unsigned KW = $clog2(NUM_OPS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = KW + DWidth;

  // Memory map. These values match pkg_memorymap.
  localparam logic [ADDR_WIDTH-1:0] NPU_IMEM_Start = ADDR_WIDTH'(32'h1000_0000);
  localparam logic [ADDR_WIDTH-1:0] NPU_IMEM_End   = ADDR_WIDTH'(32'h1000_4000);
  localparam logic [ADDR_WIDTH-1:0] NPU_WMEM_Start = ADDR_WIDTH'(32'h1001_0000);
  localparam logic [ADDR_WIDTH-1:0] NPU_WMEM_End   = ADDR_WIDTH'(32'h1001_4000);
  localparam logic [ADDR_WIDTH-1:0] NPU_BMEM_Start = ADDR_WIDTH'(32'h1002_0000);
  localparam logic [ADDR_WIDTH-1:0] NPU_BMEM_End   = ADDR_WIDTH'(32'h1002_1000);
  localparam logic [ADDR_WIDTH-1:0] NPU_OMEM_Start = ADDR_WIDTH'(32'h1003_0000);
  localparam logic [ADDR_WIDTH-1:0] NPU_OMEM_End   = ADDR_WIDTH'(32'h1003_1000);
  localparam logic [ADDR_WIDTH-1:0] NPU_PARA_Start = ADDR_WIDTH'(32'h1004_0000);
  localparam logic [ADDR_WIDTH-1:0] NPU_PARA_End   = ADDR_WIDTH'(32'h1004_0100);
  localparam logic [ADDR_WIDTH-1:0] NPU_OP_Start   = ADDR_WIDTH'(32'h1004_0100);
  localparam logic [ADDR_WIDTH-1:0] NPU_OP_End     = ADDR_WIDTH'(32'h1004_0200);

  typedef enum logic [3:0] {
    REG_NONE     = 4'b0000,
    REG_OP_SEQ   = 4'b0001,
    REG_IMEM     = 4'b1000,
    REG_WMEM     = 4'b1001,
    REG_BMEM     = 4'b1010,
    REG_OMEM     = 4'b1011,
    REG_PARA     = 4'b1100,
    REG_OP_START = 4'b1111
  } region_e;

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a,
                                  input logic [ADDR_WIDTH-1:0] lo,
                                  input logic [ADDR_WIDTH-1:0] hi);
    return (a >= lo) && (a < hi);
  endfunction

  region_e               nxt_type, type_q;
  logic                  hit, push, dec_ev;
  logic [ADDR_WIDTH-1:0] offs, op_offs;
  logic [KW-1:0]         op_k;

  always_comb begin
    hit      = 1'b0;
    push     = 1'b0;
    dec_ev   = 1'b0;
    nxt_type = REG_NONE;
    offs     = '0;
    op_offs  = addr_i - NPU_OP_Start;
    op_k     = op_offs[KW+1:2];
    if (cen_i) begin
      if (in_rng(addr_i, NPU_IMEM_Start, NPU_IMEM_End)) begin
        if (wen_i) begin hit = 1'b1; nxt_type = REG_IMEM; offs = addr_i - NPU_IMEM_Start; end
        else dec_ev = 1'b1;
      end else if (in_rng(addr_i, NPU_WMEM_Start, NPU_WMEM_End)) begin
        if (wen_i) begin hit = 1'b1; nxt_type = REG_WMEM; offs = addr_i - NPU_WMEM_Start; end
        else dec_ev = 1'b1;
      end else if (in_rng(addr_i, NPU_BMEM_Start, NPU_BMEM_End)) begin
        if (wen_i) begin hit = 1'b1; nxt_type = REG_BMEM; offs = addr_i - NPU_BMEM_Start; end
        else dec_ev = 1'b1;
      end else if (in_rng(addr_i, NPU_OMEM_Start, NPU_OMEM_End)) begin
        hit = 1'b1; nxt_type = REG_OMEM; offs = addr_i - NPU_OMEM_Start;
      end else if (in_rng(addr_i, NPU_PARA_Start, NPU_PARA_End)) begin
        hit = 1'b1; nxt_type = REG_PARA; offs = addr_i - NPU_PARA_Start;
      end else if (in_rng(addr_i, NPU_OP_Start, NPU_OP_End)) begin
        // The full word index is range-checked here. op_k alone is truncated
        // and would alias indices at or above NUM_OPS.
        if (wen_i && op_offs[1:0] == 2'b00 && (op_offs >> 2) < ADDR_WIDTH'(NUM_OPS)) begin
          push     = 1'b1;
          nxt_type = (op_k == '0) ? REG_OP_START : REG_OP_SEQ;
        end else begin
          dec_ev = 1'b1;
        end
      end else begin
        dec_ev = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_valid_o <= 1'b0;
      type_q      <= REG_NONE;
      acc_we_o    <= 1'b0;
      acc_offs_o  <= '0;
      acc_wdata_o <= '0;
    end else begin
      acc_valid_o <= hit;
      type_q      <= nxt_type;
      if (hit) begin
        acc_we_o    <= wen_i;
        acc_offs_o  <= offs;
        acc_wdata_o <= wdata_i;
      end
    end
  end

  assign op_type_o = type_q;

  // Command FIFO
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push_ok, drop;

  assign cmd_valid_o = (count != '0);
  assign busy_o      = cmd_valid_o;
  assign full        = (count == CW'(FIFO_DEPTH));
  assign pop         = cmd_valid_o & cmd_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok     = push & (~full | pop);
  assign drop        = push & full & ~pop;
  assign {cmd_op_o, cmd_arg_o} = fifo_mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= {op_k, wdata_i};
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Sticky errors: a new event outranks a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_err_o <= 1'b0;
      ovf_err_o <= 1'b0;
    end else begin
      dec_err_o <= dec_ev | (dec_err_o & ~err_clr_i);
      ovf_err_o <= drop   | (ovf_err_o & ~err_clr_i);
    end
  end

`ifdef NPU_DEC_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmd_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (push_ok)        cmd_cnt_o <= err_clr_i ? 16'd1 : ((cmd_cnt_o == '1) ? cmd_cnt_o : cmd_cnt_o + 16'd1);
      else if (err_clr_i) cmd_cnt_o <= '0;
      if (drop)           drop_cnt_o <= err_clr_i ? 16'd1 : ((drop_cnt_o == '1) ? drop_cnt_o : drop_cnt_o + 16'd1);
      else if (err_clr_i) drop_cnt_o <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_npu_cmd_decoder.sv
// Directed self-checking bench for npu_cmd_decoder (default parameters).
module tb_npu_cmd_decoder;

  localparam logic [31:0] IMEM_S = 32'h1000_0000;
  localparam logic [31:0] IMEM_E = 32'h1000_4000;
  localparam logic [31:0] WMEM_S = 32'h1001_0000;
  localparam logic [31:0] BMEM_E = 32'h1002_1000;
  localparam logic [31:0] OMEM_S = 32'h1003_0000;
  localparam logic [31:0] PARA_S = 32'h1004_0000;
  localparam logic [31:0] OP_S   = 32'h1004_0100;
  localparam logic [31:0] UNMAP  = 32'h2000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i, cen_i, wen_i, cmd_ready_i, err_clr_i;
  logic [31:0] addr_i, wdata_i;
  logic        acc_valid_o, acc_we_o, cmd_valid_o, busy_o, dec_err_o, ovf_err_o;
  logic [3:0]  op_type_o;
  logic [31:0] acc_offs_o, acc_wdata_o, cmd_arg_o;
  logic [1:0]  cmd_op_o;
`ifdef NPU_DEC_PERF_CNT_EN
  logic [15:0] cmd_cnt_o, drop_cnt_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  npu_cmd_decoder #(.DWidth(32), .ADDR_WIDTH(32), .NUM_OPS(4), .FIFO_DEPTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cen_i(cen_i), .wen_i(wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .acc_valid_o(acc_valid_o), .op_type_o(op_type_o), .acc_we_o(acc_we_o),
    .acc_offs_o(acc_offs_o), .acc_wdata_o(acc_wdata_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_arg_o(cmd_arg_o), .busy_o(busy_o),
    .dec_err_o(dec_err_o), .ovf_err_o(ovf_err_o),
`ifdef NPU_DEC_PERF_CNT_EN
    .cmd_cnt_o(cmd_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one bus cycle, then return 1 time unit after the capturing edge.
  task automatic drive(input logic c, input logic w, input logic [31:0] a, input logic [31:0] d);
    cen_i = c; wen_i = w; addr_i = a; wdata_i = d;
    @(posedge clk_i); #1;
    cen_i = 1'b0; wen_i = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1; idle(); err_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; idle(); rst_i = 1'b0;
    n_cmp++; if (acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_acc_valid: got %0h expected 0", acc_valid_o); end
    n_cmp++; if (op_type_o !== 4'b0000) begin n_bad++; $display("FAIL rst_op_type: got %b expected 0000", op_type_o); end
    n_cmp++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid: got %0h/%0h expected 0/0", cmd_valid_o, busy_o); end
    n_cmp++; if (dec_err_o !== 1'b0 || ovf_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_errors: got %0h/%0h expected 0/0", dec_err_o, ovf_err_o); end
    n_cmp++; if (acc_offs_o !== 32'h0 || acc_wdata_o !== 32'h0 || acc_we_o !== 1'b0) begin n_bad++; $display("FAIL rst_acc_data: got %h/%h/%0h expected 0/0/0", acc_offs_o, acc_wdata_o, acc_we_o); end
    n_cmp++; if (cmd_op_o !== 2'd0 || cmd_arg_o !== 32'h0) begin n_bad++; $display("FAIL rst_cmd_head: got %0h/%h expected 0/0", cmd_op_o, cmd_arg_o); end
`ifdef NPU_DEC_PERF_CNT_EN
    n_cmp++; if (cmd_cnt_o !== 16'h0 || drop_cnt_o !== 16'h0) begin n_bad++; $display("FAIL rst_perf_cnt: got %h/%h expected 0/0", cmd_cnt_o, drop_cnt_o); end
`endif
  endtask

  task automatic test_mem_access();
    drive(1'b1, 1'b1, WMEM_S + 32'd8, 32'hA5);
    n_cmp++; if (acc_valid_o !== 1'b1) begin n_bad++; $display("FAIL wmem_valid: got %0h expected 1", acc_valid_o); end
    n_cmp++; if (op_type_o !== 4'b1001) begin n_bad++; $display("FAIL wmem_type: got %b expected 1001", op_type_o); end
    n_cmp++; if (acc_offs_o !== 32'd8) begin n_bad++; $display("FAIL wmem_offs: got %h expected 8", acc_offs_o); end
    n_cmp++; if (acc_wdata_o !== 32'hA5 || acc_we_o !== 1'b1) begin n_bad++; $display("FAIL wmem_data: got %h/%0h expected a5/1", acc_wdata_o, acc_we_o); end
    idle();
    n_cmp++; if (acc_valid_o !== 1'b0 || op_type_o !== 4'b0000) begin n_bad++; $display("FAIL wmem_strobe_end: got %0h/%b expected 0/0000", acc_valid_o, op_type_o); end
    n_cmp++; if (acc_wdata_o !== 32'hA5 || acc_offs_o !== 32'd8) begin n_bad++; $display("FAIL idle_hold: got %h/%h expected a5/8", acc_wdata_o, acc_offs_o); end
    drive(1'b1, 1'b0, OMEM_S + 32'h10, 32'h0);
    n_cmp++; if (acc_valid_o !== 1'b1 || op_type_o !== 4'b1011 || acc_we_o !== 1'b0 || acc_offs_o !== 32'h10) begin n_bad++; $display("FAIL omem_read: got %0h/%b/%0h/%h expected 1/1011/0/10", acc_valid_o, op_type_o, acc_we_o, acc_offs_o); end
    drive(1'b1, 1'b1, PARA_S + 32'h4, 32'h1234);
    n_cmp++; if (acc_valid_o !== 1'b1 || op_type_o !== 4'b1100 || acc_offs_o !== 32'h4 || acc_wdata_o !== 32'h1234) begin n_bad++; $display("FAIL para_write: got %0h/%b/%h/%h expected 1/1100/4/1234", acc_valid_o, op_type_o, acc_offs_o, acc_wdata_o); end
    drive(1'b1, 1'b1, BMEM_E - 32'd1, 32'h77);
    n_cmp++; if (acc_valid_o !== 1'b1 || op_type_o !== 4'b1010 || acc_offs_o !== 32'hFFF) begin n_bad++; $display("FAIL bmem_last: got %0h/%b/%h expected 1/1010/fff", acc_valid_o, op_type_o, acc_offs_o); end
    drive(1'b1, 1'b1, IMEM_S, 32'h5);
    n_cmp++; if (acc_valid_o !== 1'b1 || op_type_o !== 4'b1000 || acc_offs_o !== 32'h0) begin n_bad++; $display("FAIL imem_write: got %0h/%b/%h expected 1/1000/0", acc_valid_o, op_type_o, acc_offs_o); end
    idle();
    n_cmp++; if (dec_err_o !== 1'b0) begin n_bad++; $display("FAIL legal_no_err: got %0h expected 0", dec_err_o); end
  endtask

  task automatic test_op_fifo();
    cmd_ready_i = 1'b0;
    drive(1'b1, 1'b1, OP_S, 32'h11);
    n_cmp++; if (op_type_o !== 4'b1111 || acc_valid_o !== 1'b0) begin n_bad++; $display("FAIL op0_type: got %b/%0h expected 1111/0", op_type_o, acc_valid_o); end
    n_cmp++; if (cmd_valid_o !== 1'b1) begin n_bad++; $display("FAIL op0_cmd_valid: got %0h expected 1", cmd_valid_o); end
    drive(1'b1, 1'b1, OP_S + 32'd12, 32'h22);
    n_cmp++; if (op_type_o !== 4'b0001) begin n_bad++; $display("FAIL op3_type: got %b expected 0001", op_type_o); end
    idle(); idle();
    n_cmp++; if (cmd_op_o !== 2'd0 || cmd_arg_o !== 32'h11 || busy_o !== 1'b1) begin n_bad++; $display("FAIL head_stable: got %0h/%h/%0h expected 0/11/1", cmd_op_o, cmd_arg_o, busy_o); end
    cmd_ready_i = 1'b1; idle();
    n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== 2'd3 || cmd_arg_o !== 32'h22) begin n_bad++; $display("FAIL head_second: got %0h/%0h/%h expected 1/3/22", cmd_valid_o, cmd_op_o, cmd_arg_o); end
    idle();
    n_cmp++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL fifo_drained: got %0h/%0h expected 0/0", cmd_valid_o, busy_o); end
    cmd_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] exp_arg [3];
    logic [1:0]  exp_k   [3];
    exp_arg = '{32'h102, 32'h103, 32'h200};
    exp_k   = '{2'd2, 2'd3, 2'd1};
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, OP_S + 32'(4 * (i % 4)), 32'h100 + 32'(i));
      if (i == 3) begin
        n_cmp++; if (ovf_err_o !== 1'b0) begin n_bad++; $display("FAIL full_no_ovf: got %0h expected 0", ovf_err_o); end
      end
    end
    n_cmp++; if (ovf_err_o !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %0h expected 1", ovf_err_o); end
    n_cmp++; if (cmd_op_o !== 2'd0 || cmd_arg_o !== 32'h100) begin n_bad++; $display("FAIL ovf_head: got %0h/%h expected 0/100", cmd_op_o, cmd_arg_o); end
    clear_errors();
    n_cmp++; if (ovf_err_o !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %0h expected 0", ovf_err_o); end
    cmd_ready_i = 1'b1;
    drive(1'b1, 1'b1, OP_S + 32'd4, 32'h200);
    n_cmp++; if (ovf_err_o !== 1'b0) begin n_bad++; $display("FAIL full_pop_push: got %0h expected 0", ovf_err_o); end
    n_cmp++; if (cmd_op_o !== 2'd1 || cmd_arg_o !== 32'h101) begin n_bad++; $display("FAIL pop_push_head: got %0h/%h expected 1/101", cmd_op_o, cmd_arg_o); end
    for (int i = 0; i < 3; i++) begin
      idle();
      n_cmp++; if (cmd_valid_o !== 1'b1 || cmd_op_o !== exp_k[i] || cmd_arg_o !== exp_arg[i]) begin n_bad++; $display("FAIL drain_%0d: got %0h/%0h/%h expected 1/%0h/%h", i, cmd_valid_o, cmd_op_o, cmd_arg_o, exp_k[i], exp_arg[i]); end
    end
    idle();
    n_cmp++; if (cmd_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %0h expected 0", cmd_valid_o); end
    cmd_ready_i = 1'b0;
  endtask

  task automatic test_decode_err();
    drive(1'b1, 1'b0, IMEM_S, 32'h0);
    n_cmp++; if (op_type_o !== 4'b0000 || acc_valid_o !== 1'b0 || dec_err_o !== 1'b1) begin n_bad++; $display("FAIL imem_read_err: got %b/%0h/%0h expected 0000/0/1", op_type_o, acc_valid_o, dec_err_o); end
    clear_errors();
    n_cmp++; if (dec_err_o !== 1'b0) begin n_bad++; $display("FAIL dec_clear1: got %0h expected 0", dec_err_o); end
    drive(1'b1, 1'b1, UNMAP, 32'h9);
    n_cmp++; if (op_type_o !== 4'b0000 || dec_err_o !== 1'b1) begin n_bad++; $display("FAIL unmapped_err: got %b/%0h expected 0000/1", op_type_o, dec_err_o); end
    err_clr_i = 1'b1;
    drive(1'b1, 1'b1, UNMAP, 32'h9);
    err_clr_i = 1'b0;
    n_cmp++; if (dec_err_o !== 1'b1) begin n_bad++; $display("FAIL err_wins_clr: got %0h expected 1", dec_err_o); end
    clear_errors();
    n_cmp++; if (dec_err_o !== 1'b0) begin n_bad++; $display("FAIL dec_clear2: got %0h expected 0", dec_err_o); end
    drive(1'b1, 1'b1, IMEM_E, 32'h1);
    n_cmp++; if (acc_valid_o !== 1'b0 || dec_err_o !== 1'b1) begin n_bad++; $display("FAIL imem_end_excl: got %0h/%0h expected 0/1", acc_valid_o, dec_err_o); end
    clear_errors();
  endtask

  task automatic test_op_illegal();
    cmd_ready_i = 1'b0;
    drive(1'b1, 1'b1, OP_S + 32'd16, 32'h3);
    n_cmp++; if (dec_err_o !== 1'b1 || cmd_valid_o !== 1'b0 || op_type_o !== 4'b0000) begin n_bad++; $display("FAIL op_k_range: got %0h/%0h/%b expected 1/0/0000", dec_err_o, cmd_valid_o, op_type_o); end
    clear_errors();
    drive(1'b1, 1'b1, OP_S + 32'd2, 32'h3);
    n_cmp++; if (dec_err_o !== 1'b1 || cmd_valid_o !== 1'b0) begin n_bad++; $display("FAIL op_unaligned: got %0h/%0h expected 1/0", dec_err_o, cmd_valid_o); end
    clear_errors();
    drive(1'b1, 1'b0, OP_S + 32'd4, 32'h0);
    n_cmp++; if (dec_err_o !== 1'b1 || cmd_valid_o !== 1'b0) begin n_bad++; $display("FAIL op_read: got %0h/%0h expected 1/0", dec_err_o, cmd_valid_o); end
    clear_errors();
  endtask

  task automatic test_reset_mid();
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, OP_S + 32'(4 * i), 32'h40 + 32'(i));
    drive(1'b1, 1'b1, UNMAP, 32'h0);
    n_cmp++; if (cmd_valid_o !== 1'b1 || dec_err_o !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got %0h/%0h expected 1/1", cmd_valid_o, dec_err_o); end
    rst_i = 1'b1; idle(); rst_i = 1'b0;
    n_cmp++; if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_fifo: got %0h/%0h expected 0/0", cmd_valid_o, busy_o); end
    n_cmp++; if (dec_err_o !== 1'b0 || ovf_err_o !== 1'b0 || op_type_o !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_state: got %0h/%0h/%b expected 0/0/0000", dec_err_o, ovf_err_o, op_type_o); end
    idle();
    n_cmp++; if (cmd_valid_o !== 1'b0 || cmd_arg_o !== 32'h0) begin n_bad++; $display("FAIL mid_rst_empty: got %0h/%h expected 0/0", cmd_valid_o, cmd_arg_o); end
  endtask

  initial begin
    rst_i = 1'b1; cen_i = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0;
    cmd_ready_i = 1'b0; err_clr_i = 1'b0;
    test_reset();
    test_mem_access();
    test_op_fifo();
    test_overflow();
    test_decode_err();
    test_op_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
